// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op encodings, response flag bit
// positions and the sequencer state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    localparam int FLAG_SIGN   = 0;
    localparam int FLAG_ZERO   = 1;
    localparam int FLAG_PARITY = 2;
    localparam int FLAG_OVF    = 3;
    localparam int FLAG_CARRY  = 4;
    localparam int FLAG_ERR    = 5;
    localparam int FLAG_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_div_zero(input logic [2:0] op, input logic [7:0] b);
        return (op == OP_DIV) && (b == 8'h00);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// `last`, wrapping around, as a one-hot grant plus its index.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDXW  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDXW-1:0]  idx
);

    logic found;

    // Outer loop walks priority order, inner loop keeps all indices constant.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % N_REQ)) begin
                    found  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one external 8-bit ALU between N_REQ
// requesters: accept, execute for one cycle, hold the response until consumed.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [7:0]           rsp_result,
    output logic [FLAG_W-1:0]    rsp_flags,
    output logic [IDXW-1:0]      rsp_id,
    output logic                 busy,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    input  logic [7:0]           alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_sign,
    input  logic                 alu_parity,
    input  logic                 alu_overflow,
    input  logic                 alu_zero
);

    state_e              state_q, state_d;
    logic [IDXW-1:0]     last_grant_q, last_grant_d;
    logic [IDXW-1:0]     rsp_id_q, rsp_id_d;
    logic [2:0]          op_q, op_d;
    logic [7:0]          a_q, a_d;
    logic [7:0]          b_q, b_d;
    logic [7:0]          result_q, result_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic [N_REQ-1:0]    gnt;
    logic [IDXW-1:0]     win_idx;
    logic [2:0]          win_op;
    logic [7:0]          win_a, win_b;
    logic                accept;
    logic                rsp_hs;

    rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
        .req  (req_valid),
        .last (last_grant_q),
        .gnt  (gnt),
        .idx  (win_idx)
    );

    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_op = req_op[3*i +: 3];
                win_a  = req_a[8*i +: 8];
                win_b  = req_b[8*i +: 8];
            end
        end
    end

    // Output decode; req_ready is also held low while reset is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_q != ST_IDLE);
        if (state_q == ST_IDLE && rst_n)
            req_ready = gnt;
        if (state_q == ST_RESP) begin
            for (int i = 0; i < N_REQ; i++)
                rsp_valid[i] = (rsp_id_q == IDXW'(i));
        end
    end

    assign accept = (state_q == ST_IDLE) && |(req_valid & req_ready);
    assign rsp_hs = |(rsp_valid & rsp_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_hs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        flags_d      = flags_q;
        if (accept) begin
            last_grant_d = win_idx;
            rsp_id_d     = win_idx;
            op_d         = win_op;
            a_d          = win_a;
            b_d          = win_b;
        end
        if (state_q == ST_EXEC) begin
            flags_d = '0;
            if (is_div_zero(op_q, b_q)) begin
                result_d           = 8'hFF;
                flags_d[FLAG_ERR]  = 1'b1;
            end else begin
                result_d             = alu_result;
                flags_d[FLAG_SIGN]   = alu_sign;
                flags_d[FLAG_ZERO]   = alu_zero;
                flags_d[FLAG_PARITY] = alu_parity;
                flags_d[FLAG_OVF]    = alu_overflow;
                // ALU carry is only meaningful for ADD
                flags_d[FLAG_CARRY]  = alu_carry && (op_q == OP_ADD);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDXW'(N_REQ - 1);
            rsp_id_q     <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign rsp_id     = rsp_id_q;

    // A pending request must stay asserted until it is accepted.
    for (genvar i = 0; i < N_REQ; i++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            req_valid[i] && !req_ready[i] |=> req_valid[i]);
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* ports.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N    = 2;
    localparam int IDXW = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3*N-1:0]   req_op;
    logic [8*N-1:0]   req_a, req_b;
    logic [7:0]       rsp_result;
    logic [5:0]       rsp_flags;
    logic [IDXW-1:0]  rsp_id;
    logic             busy;
    logic [7:0]       alu_a, alu_b, alu_result;
    logic [2:0]       alu_op;
    logic             alu_carry, alu_sign, alu_parity, alu_overflow, alu_zero;

    int total = 0;
    int bad   = 0;
    int n, exp_id, last_id;
    logic [N-1:0] pd;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_id(rsp_id),
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign),
        .alu_parity(alu_parity), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
    );

    // Team ALU model; its carry output is junk (1) for every op but ADD.
    logic [8:0] sum;
    always_comb begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = 8'h00;
        alu_carry    = 1'b1;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_result   = sum[7:0];
                alu_carry    = sum[8];
                alu_overflow = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
            end
            OP_SUB: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            OP_MUL:  alu_result = alu_a * alu_b;
            OP_DIV:  alu_result = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            default: alu_result = ~(alu_a ^ alu_b);
        endcase
        alu_sign   = alu_result[7];
        alu_zero   = (alu_result == 8'h00);
        alu_parity = ^alu_result;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int i, input string tag);
        logic [N-1:0] m;
        int c;
        m = N'(1) << i;
        c = 0;
        while ((req_ready & m) == '0 && c < 20) begin
            @(negedge clk); #1; c++;
        end
        chk(tag, 32'(req_ready), 32'(m));
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 20) begin
            @(negedge clk); #1; c++;
        end
        chk("idle", 32'(busy), 0);
    endtask

    // Keeps serving pending requests, dropping each valid right after its acceptance.
    task automatic drain();
        logic [N-1:0] dp;
        int c;
        dp = req_ready;
        c  = 0;
        while (req_valid != '0 && c < 40) begin
            @(negedge clk);
            req_valid = req_valid & ~dp;
            #1;
            dp = req_ready;
            c++;
        end
        chk("drain", 32'(req_valid), 0);
        wait_idle();
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // Single op with rsp_ready[i] high: accept, EXEC, RESP, back to IDLE.
    task automatic run_op(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [5:0] ef, input string tag);
        @(negedge clk);
        set_req(i, op, a, b);
        req_valid[i] = 1'b1;
        #1;
        wait_ready(i, {tag, "_acc"});
        @(negedge clk);
        req_valid[i] = 1'b0;
        #1;
        chk({tag, "_exec"}, {29'd0, busy, rsp_valid}, {29'd0, 1'b1, 2'b00});
        chk({tag, "_opnd"}, {13'd0, alu_op, alu_a, alu_b}, {13'd0, op, a, b});
        @(negedge clk); #1;
        chk({tag, "_vld"}, 32'(rsp_valid), 32'(1) << i);
        chk({tag, "_id"}, 32'(rsp_id), i);
        chk({tag, "_res"}, 32'(rsp_result), 32'(er));
        chk({tag, "_flg"}, 32'(rsp_flags), 32'(ef));
        @(negedge clk); #1;
        chk({tag, "_done"}, {29'd0, busy, rsp_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ctl", {27'd0, req_ready, rsp_valid, busy}, 0);
        chk("rst_rsp", {17'd0, rsp_id, rsp_result, rsp_flags}, 0);
        chk("rst_alu", {13'd0, alu_op, alu_a, alu_b}, 0);

        run_op(0, OP_ADD, 8'hF0, 8'h20, 8'h10, 6'b010100, "add");
        run_op(1, OP_SUB, 8'h05, 8'h03, 8'h02, 6'b000100, "sub");
        chk("sub_carry", 32'(rsp_flags[FLAG_CARRY]), 0);

        // Round robin: both hold valid; grants must alternate starting at 0.
        req_op = {OP_AND, OP_AND};
        req_a  = {8'h0F, 8'hF0};
        req_b  = {8'h3C, 8'h3C};
        n = 0; exp_id = 0; last_id = 0; pd = '0;
        @(negedge clk);
        req_valid = 2'b11;
        for (int c = 0; c < 60 && n < 5; c++) begin
            #1;
            if (rsp_valid != '0) begin
                chk("rr_id", 32'(rsp_id), last_id);
                chk("rr_res", 32'(rsp_result), (last_id == 1) ? 32'h0C : 32'h30);
            end
            if (req_ready != '0) begin
                chk("rr_gnt", 32'(req_ready), 32'(1) << exp_id);
                last_id = exp_id;
                exp_id  = 1 - exp_id;
                n++;
                if (n >= 4) pd = req_ready;
            end
            @(negedge clk);
            req_valid = req_valid & ~pd;
            pd = '0;
        end
        chk("rr_count", n, 5);
        wait_idle();

        run_op(0, OP_DIV, 8'h42, 8'h00, 8'hFF, 6'b100000, "div0");
        run_op(0, OP_DIV, 8'h42, 8'h06, 8'h0B, 6'b000100, "div6");

        // Response backpressure with a stray rsp_ready on the wrong requester.
        rsp_ready = 2'b10;
        @(negedge clk);
        set_req(0, OP_XOR, 8'hAA, 8'h0F);
        req_valid = 2'b01;
        #1;
        wait_ready(0, "bp_acc");
        @(negedge clk);
        req_valid = 2'b10;
        set_req(1, OP_OR, 8'h01, 8'h02);
        #1;
        chk("bp_exec_rdy", 32'(req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("bp_hold", {13'd0, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready},
                {13'd0, 2'b01, 1'b0, 8'hA5, 6'b000001, 2'b00});
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        @(negedge clk); #1;
        chk("bp_next", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        chk("bp_rsp1", {15'd0, rsp_valid, rsp_id, rsp_result, rsp_flags},
            {15'd0, 2'b10, 1'b1, 8'h03, 6'b000000});
        wait_idle();

        // Reset while in EXEC with requester 1 pending.
        @(negedge clk);
        set_req(0, OP_ADD, 8'h01, 8'h01);
        req_valid = 2'b01;
        #1;
        wait_ready(0, "rx_acc");
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("rx_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rx_ctl", {27'd0, req_ready, rsp_valid, busy}, 0);
        chk("rx_alu", 32'(alu_a), 0);
        req_valid = 2'b11;
        #1;
        chk("rx_rdy", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rx_first", 32'(req_ready), 32'b01);
        drain();

        // Reset while in RESP.
        rsp_ready = 2'b00;
        @(negedge clk);
        set_req(0, OP_XOR, 8'hAA, 8'h0F);
        req_valid = 2'b01;
        #1;
        wait_ready(0, "rr2_acc");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        chk("rr2_resp", 32'(rsp_valid), 32'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("rr2_ctl", {27'd0, req_ready, rsp_valid, busy}, 0);
        chk("rr2_rsp", {18'd0, rsp_result, rsp_flags}, 0);
        req_valid = 2'b11;
        #1;
        chk("rr2_rdy", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        #1;
        chk("rr2_first", 32'(req_ready), 32'b01);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
